// File: rtl/output_register_skid_input.sv
// output_register_skid_input
// Two-entry valid/ready skid buffer feeding the I0 input of the output
// register pipeline. I0_ready and O0_valid are decoded straight from the
// state flops, so neither handshake has a combinational path through here.
// O0 is driven directly from the main register.
//
// Optional feature, enabled by defining SKID_STALL_COUNT_EN:
//   adds STALL_CNT, a saturating count of cycles with O0_valid=1 and O0_ready=0.
module output_register_skid_input #(
    parameter int WIDTH = 1
`ifdef SKID_STALL_COUNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic             I0_valid,
    output logic             I0_ready,
    output logic [WIDTH-1:0] O0,
    output logic             O0_valid,
    input  logic             O0_ready
`ifdef SKID_STALL_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] STALL_CNT
`endif
);

    // EMPTY: no entries; BUSY: main holds one; FULL: main and skid both hold one.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign I0_ready = (state_q != FULL);
    assign O0_valid = (state_q != EMPTY);
    assign O0       = main_q;

    assign in_fire  = I0_valid & I0_ready;
    assign out_fire = O0_valid & O0_ready;

    // Next-state and storage-load decode for the three occupancy states.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = I0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = I0;
                end else if (in_fire) begin
                    skid_d  = I0;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // I0_ready is low here, so only the drain side can fire.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and data registers; reset discards any held entries at once.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= EMPTY;
            // NOTE: the data registers are reset too, because O0 must read zero during reset rather than a stale word.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_STALL_COUNT_EN
    logic stall;
    assign stall = O0_valid & ~O0_ready;

    // Saturating stall counter; it never wraps and only reset clears it.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            STALL_CNT <= '0;
        end else if (stall && (STALL_CNT != {CNT_WIDTH{1'b1}})) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: doc/output_register_skid_input.md
Name: output_register_skid_input

Overview:
- Two-entry valid/ready skid buffer that sits directly upstream of the output register pipeline and feeds its I0 data input.
- Decouples the producer from backpressure at full throughput, so every path between the two stages is register-to-register.
- The retiming and extraction flow can then treat the ready path as registered.

Parameters:
- WIDTH, 1, data width in bits of I0/O0 and of both storage registers.
- CNT_WIDTH, 16, width of the stall counter; used only when SKID_STALL_COUNT_EN is defined.

Ports:
- CLK  input  1  single clock; all state updates on the posedge.
- ASYNCRESETN  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- I0  input  WIDTH  upstream data; sampled only on an input fire.
- I0_valid  input  1  upstream data valid.
- I0_ready  output  1  buffer can accept data; decoded directly from state flops.
- O0  output  WIDTH  downstream data, driven straight from the main register.
- O0_valid  output  1  O0 holds valid data.
- O0_ready  input  1  downstream accepts O0 this cycle.
- STALL_CNT  output  CNT_WIDTH  present only with SKID_STALL_COUNT_EN.

Behaviour:
- Fire definitions:
  - in_fire = I0_valid & I0_ready.
  - out_fire = O0_valid & O0_ready.
- Storage: main register MAIN drives O0; skid register SKID holds the overflow entry.
- State register values: EMPTY (0 entries), BUSY (MAIN full), FULL (MAIN and SKID full).
- Output decode:
  - O0_valid = (state != EMPTY).
  - I0_ready = (state != FULL).
  - Both are pure decodes of the state flops, with no combinational path from any input.
- EMPTY:
  - in_fire: MAIN <= I0, go to BUSY.
  - Otherwise: hold.
- BUSY:
  - in_fire & out_fire: MAIN <= I0, stay BUSY.
  - in_fire only: SKID <= I0, go to FULL.
  - out_fire only: go to EMPTY.
  - Neither: hold.
- FULL:
  - in_fire is impossible because I0_ready = 0.
  - out_fire: MAIN <= SKID, go to BUSY.
  - Otherwise: hold.
- Latency and throughput:
  - Latency I0 -> O0 is 1 cycle; data accepted at edge N appears on O0 after edge N.
  - Sustained throughput is 1 word/cycle when O0_ready is held high.
- Ordering and stability:
  - Strict FIFO order; no drop, no duplication.
  - While O0_valid=1 and O0_ready=0, O0 and O0_valid are stable cycle to cycle.
- I0 is ignored when I0_valid=0. Any I0_valid/I0 value while I0_ready=0 is ignored.
- Reset values (ASYNCRESETN low, asserted asynchronously):
  - state = EMPTY, MAIN = 0, SKID = 0.
  - O0_valid = 0, O0 = 0, I0_ready = 1, STALL_CNT = 0.
- Reset deassertion is synchronous to CLK at the integration level. The first possible fire is on the first posedge after release.
- Reset mid-operation: all held entries are discarded immediately, with no partial output.
- O0_ready is a don't-care while O0_valid = 0.

Optional Feature:
- Macro: SKID_STALL_COUNT_EN.
- Defined:
  - Adds output STALL_CNT[CNT_WIDTH-1:0].
  - Increments by 1 on each cycle with O0_valid=1 & O0_ready=0.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Cleared only by reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset check: hold ASYNCRESETN=0 mid-stream with the buffer FULL (0x5, 0x6) -> O0_valid=0, I0_ready=1, O0=0 immediately, without waiting for a clock edge. After release, the next word accepted appears first, and 0x5/0x6 never appear.
2. Streaming: WIDTH=4, O0_ready=1, I0_valid=1 with I0=0x1,0x2,0x3 on consecutive edges -> O0 = 0x1,0x2,0x3 one cycle later, O0_valid continuous, I0_ready stays 1.
3. Backpressure:
   - Stimulus: accept 0xA then 0xB with O0_ready=0.
   - Fill: state FULL, I0_ready=0, O0=0xA stable. Offered 0xC is not accepted.
   - Drain: raise O0_ready -> O0 shows 0xA, 0xB, then 0xC, in order with no gaps beyond handshake stalls.
4. Simultaneous fire in BUSY: MAIN=0x3, I0=0x4 valid, O0_ready=1 -> next cycle O0=0x4, state BUSY, SKID untouched.
5. Random valid/ready (≥10k cycles, seeded), checked with a scoreboard:
   - Output sequence equals input sequence.
   - Never more than 2 words in flight.
   - O0 never changes while O0_valid & !O0_ready.
6. SKID_STALL_COUNT_EN with CNT_WIDTH=2: hold O0_valid=1, O0_ready=0 for 5 cycles -> STALL_CNT = 1,2,3,3,3 (saturates, no wrap).
